// File: rtl/pp_combine_54.sv
// Two-stage shift-and-add combiner for the six 27x18 partial products of a 54x54 unsigned multiply.
// One global advance moves both stages together, so backpressure on prod stalls the whole pipe.
module pp_combine_54 #(
    parameter int RADIX = 54,
    parameter int PP_W  = 45,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PP_W-1:0]      res_0,
    input  logic [PP_W-1:0]      res_1,
    input  logic [PP_W-1:0]      res_2,
    input  logic [PP_W-1:0]      res_3,
    input  logic [PP_W-1:0]      res_4,
    input  logic [PP_W-1:0]      res_5,
    output logic [2*RADIX-1:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     prod_count
);

    // A row is a 27x54 product: PP_W bits plus the 36-bit shift of its top term.
    localparam int ROW_W  = PP_W + 36;
    localparam int PROD_W = 2 * RADIX;

    logic              adv;
    logic              v1_d, v1_q;
    logic [ROW_W-1:0]  row_lo_d, row_lo_q;
    logic [ROW_W-1:0]  row_hi_d, row_hi_q;
    logic              out_valid_d, out_valid_q;
    logic [PROD_W-1:0] prod_d, prod_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    assign adv = !out_valid_q || out_ready;

    always_comb begin
        // NOTE: every target gets its hold value first, so the !adv path cannot infer a latch.
        v1_d        = v1_q;
        row_lo_d    = row_lo_q;
        row_hi_d    = row_hi_q;
        out_valid_d = out_valid_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;

        if (adv) begin
            v1_d        = in_valid;
            row_lo_d    = ROW_W'(res_0) + (ROW_W'(res_1) << 18) + (ROW_W'(res_2) << 36);
            row_hi_d    = ROW_W'(res_3) + (ROW_W'(res_4) << 18) + (ROW_W'(res_5) << 36);
            out_valid_d = v1_q;
            prod_d      = PROD_W'(row_lo_q) + (PROD_W'(row_hi_q) << 27);
        end

        if (out_valid_q && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so no stale product is visible after a mid-stream reset.
            v1_q        <= 1'b0;
            row_lo_q    <= '0;
            row_hi_q    <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking updates let stage 2 sample the pre-edge stage 1 values.
            v1_q        <= v1_d;
            row_lo_q    <= row_lo_d;
            row_hi_q    <= row_hi_d;
            out_valid_q <= out_valid_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign prod       = prod_q;
    assign prod_count = cnt_q;

endmodule

// File: tb/tb_pp_combine_54.sv
// Directed bench for pp_combine_54: single-term weights, full scale, streaming, backpressure,
// asynchronous mid-stream reset and a 4-bit counter instance for saturation.
module tb_pp_combine_54;

    localparam int PP_W   = 45;
    localparam int PROD_W = 108;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PP_W-1:0]   res_0, res_1, res_2, res_3, res_4, res_5;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       prod_count;

    logic              in_ready_s;
    logic [PROD_W-1:0] prod_s;
    logic              out_valid_s;
    logic [3:0]        prod_count_s;

    int checks   = 0;
    int failures = 0;
    logic [PROD_W-1:0] exp_q[$];
    logic [53:0] a_x, b_x;

    always #5 clk = ~clk;

    pp_combine_54 #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .res_0(res_0), .res_1(res_1), .res_2(res_2), .res_3(res_3), .res_4(res_4), .res_5(res_5),
        .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .prod_count(prod_count)
    );

    pp_combine_54 #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .res_0(res_0), .res_1(res_1), .res_2(res_2), .res_3(res_3), .res_4(res_4), .res_5(res_5),
        .prod(prod_s), .out_valid(out_valid_s), .out_ready(out_ready), .prod_count(prod_count_s)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic [PP_W-1:0] r0, r1, r2, r3, r4, r5);
        res_0 = r0; res_1 = r1; res_2 = r2;
        res_3 = r3; res_4 = r4; res_5 = r5;
    endtask

    function automatic logic [PROD_W-1:0] model(input logic [53:0] a, input logic [53:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    // Partial products exactly as the DSP stage produces them.
    task automatic drive_ab(input logic [53:0] a, input logic [53:0] b);
        logic [PP_W-1:0] al, ah, b0, b1, b2;
        al = PP_W'(a[26:0]);
        ah = PP_W'(a[53:27]);
        b0 = PP_W'(b[17:0]);
        b1 = PP_W'(b[35:18]);
        b2 = PP_W'(b[53:36]);
        drive_res(al * b0, al * b1, al * b2, ah * b0, ah * b1, ah * b2);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    // Inputs must already be driven; checks the 2-cycle latency and then lets the product deliver.
    task automatic single_shot(input string tag, input logic [PROD_W-1:0] expected);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        drive_res('0, '0, '0, '0, '0, '0);
        check({tag, "_early"}, 128'(out_valid), 128'(0));
        cyc();
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        check(tag, 128'(prod), 128'(expected));
        cyc();
    endtask

    task automatic run_stream(input string tag, input int n, input bit bp);
        int sent = 0;
        int got = 0;
        int cycles = 0;
        bit pending = 1'b0;
        bit stalled = 1'b0;
        logic [PROD_W-1:0] held = '0;
        logic [PROD_W-1:0] cur = '0;
        logic [53:0] a, b;
        while ((sent < n || exp_q.size() > 0) && cycles < 20 * n + 10) begin
            if (!pending && sent < n) begin
                a = 54'({$urandom(), $urandom()});
                b = 54'({$urandom(), $urandom()});
                drive_ab(a, b);
                cur      = model(a, b);
                in_valid = 1'b1;
                pending  = 1'b1;
            end else if (!pending) begin
                in_valid = 1'b0;
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            check({tag, "_in_ready"}, 128'(in_ready), 128'(!out_valid || out_ready));
            if (stalled) begin
                check({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
                check({tag, "_hold_prod"}, 128'(prod), 128'(held));
            end
            if (out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra"}, 128'(out_valid), 128'(0));
                end else begin
                    check({tag, "_data"}, 128'(prod), 128'(exp_q.pop_front()));
                    got++;
                end
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = prod;
            if (in_valid && in_ready) begin
                exp_q.push_back(cur);
                pending = 1'b0;
                sent++;
            end
            cyc();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
        check({tag, "_got"}, 128'(got), 128'(n));
        if (!bp) check({tag, "_cycles"}, 128'(cycles), 128'(n + 2));
        exp_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_res('0, '0, '0, '0, '0, '0);
        repeat (2) cyc();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_prod", 128'(prod), 128'(0));
        check("rst_count", 128'(prod_count), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_sat_valid", 128'(out_valid_s), 128'(0));
        check("rst_sat_prod", 128'(prod_s), 128'(0));
        check("rst_sat_in_ready", 128'(in_ready_s), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        drive_res(1, 0, 0, 0, 0, 0);
        single_shot("w_res0", 108'h1);
        drive_res(0, 0, 0, 0, 0, 1);
        single_shot("w_res5", 108'h8000_0000_0000_0000);
        drive_res(0, 0, 0, 1, 0, 0);
        single_shot("w_res3", 108'h800_0000);
        drive_res(1, 1, 1, 1, 1, 1);
        single_shot("w_all_terms", 108'h8000_2010_0804_0001);
        drive_ab('1, '1);
        single_shot("full_scale", 108'hFFFFFFFFFFFFF_8_0000000000001);
        check("directed_count", 128'(prod_count), 128'(5));
        check("directed_sat_count", 128'(prod_count_s), 128'(5));

        // Two sets in flight, then an asynchronous reset between clock edges.
        out_ready = 1'b1;
        drive_ab(54'h12345_6789ABCD, 54'h3F_0F0F_0F0F_0F0F);
        in_valid = 1'b1;
        cyc();
        drive_ab(54'h2A_AAAA_5555_1234, 54'h00_FFFF_0000_FFFF);
        cyc();
        in_valid = 1'b0;
        drive_res('0, '0, '0, '0, '0, '0);
        check("midrst_pre_valid", 128'(out_valid), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_prod", 128'(prod), 128'(0));
        check("midrst_count", 128'(prod_count), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("midrst_no_stale", 128'(out_valid), 128'(0));
        a_x = 54'h3C_DEAD_BEEF_0123;
        b_x = 54'h01_2345_6789_ABCD;
        drive_ab(a_x, b_x);
        single_shot("post_rst", model(a_x, b_x));

        do_reset();
        run_stream("stream", 100, 1'b0);
        check("stream_count", 128'(prod_count), 128'(100));
        check("sat_count", 128'(prod_count_s), 128'(15));

        run_stream("bp", 60, 1'b1);
        check("bp_count", 128'(prod_count), 128'(160));
        check("bp_sat_count", 128'(prod_count_s), 128'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
